// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler
//   Shares one SAR-ADC among NUM_REQ requesters. Arbitration is round-robin.
//   The block drives the ADC config and start lines and waits for the
//   finished flag. The 16-bit result goes back tagged with the requester ID
//   over a valid/ready handshake.
//
// Ports
//   clk, rst_n              system clock, async active-low reset
//   req_i                   level request per requester
//   req_config_1/2_i        16-bit config words, slice k = requester k
//   timeout_i               WAIT timeout in cycles, 0 disables
//   grant_o                 one-hot 1-cycle pulse on acceptance
//   res_valid_o/res_ready_i result handshake
//   res_data_o/res_id_o     result word and requester index
//   res_timeout_o           result produced by timeout (data = 0)
//   busy_o                  FSM not in IDLE
//   adc_start_o             ADC start_conversion_in
//   adc_config_1/2_o        ADC config_1_in / config_2_in
//   adc_result_i            ADC result_out
//   adc_finished_i          ADC conversion_finished_out (async to clk)
//
// Optional build macro: ADC_SCHED_PERIODIC_EN
//   Adds trig_period_i (16b) and a sticky trig_ovf_o. The block raises a
//   periodic internal request for requester 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate; on a request, grant and load config
// SETUP | config held stable before start
// START | adc_start_o high for START_CYCLES cycles
// WAIT  | wait for fresh finished edge or timeout
// RESP  | present result until consumer accepts
module adc_conv_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int START_CYCLES = 4,
  parameter int TIMEOUT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef ADC_SCHED_PERIODIC_EN
  input  logic [15:0]            trig_period_i,
  output logic                   trig_ovf_o,
`endif
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [16*NUM_REQ-1:0]  req_config_1_i,
  input  logic [16*NUM_REQ-1:0]  req_config_2_i,
  input  logic [TIMEOUT_W-1:0]   timeout_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [15:0]            res_data_o,
  output logic [2:0]             res_id_o,
  output logic                   res_timeout_o,
  output logic                   busy_o,
  output logic                   adc_start_o,
  output logic [15:0]            adc_config_1_o,
  output logic [15:0]            adc_config_2_o,
  input  logic [15:0]            adc_result_i,
  input  logic                   adc_finished_i
);

  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int TW = $clog2(START_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [2:0]           id_q, id_d;
  logic [15:0]          cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [SW-1:0]        setup_cnt_q, setup_cnt_d;
  logic [TW-1:0]        start_cnt_q, start_cnt_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic [15:0]          res_data_q, res_data_d;
  logic                 res_tmo_q, res_tmo_d;
  logic                 res_valid_q, res_valid_d;
  logic                 start_q, start_d;
  logic                 fin_s1_q, fin_s2_q, fin_s3_q;
  logic                 fin_rise;

  logic [NUM_REQ-1:0]   req_eff;
  logic [7:0]           req_pad;
  logic [15:0]          cfg1_arr [8];
  logic [15:0]          cfg2_arr [8];
  logic                 arb_found;
  logic [2:0]           arb_idx;

  // Unpack config buses into a fixed 8-entry table so the arbiter can
  // index with exactly 3 bits regardless of NUM_REQ.
  for (genvar g = 0; g < 8; g++) begin : g_cfg
    if (g < NUM_REQ) begin : g_used
      assign cfg1_arr[g] = req_config_1_i[16*g +: 16];
      assign cfg2_arr[g] = req_config_2_i[16*g +: 16];
    end else begin : g_unused
      assign cfg1_arr[g] = 16'h0000;
      assign cfg2_arr[g] = 16'h0000;
    end
  end

`ifdef ADC_SCHED_PERIODIC_EN
  logic [15:0] per_cnt_q, per_cnt_d;
  logic        pend_q, pend_d;
  logic        ovf_q, ovf_d;
  logic        tick, grant0;

  always_comb begin
    tick      = (trig_period_i != 16'h0000) && (per_cnt_q >= trig_period_i - 16'd1);
    grant0    = (state_q == IDLE) && arb_found && (arb_idx == 3'd0);
    per_cnt_d = (tick || trig_period_i == 16'h0000) ? 16'h0000 : per_cnt_q + 16'd1;
    // A tick coinciding with the grant of requester 0 starts a new pending.
    pend_d    = tick | (pend_q & ~grant0);
    ovf_d     = ovf_q | (tick & pend_q & ~grant0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= 16'h0000;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
    end
  end

  assign trig_ovf_o = ovf_q;
  assign req_eff    = req_i | NUM_REQ'(pend_q);
`else
  assign req_eff    = req_i;
`endif

  assign req_pad  = 8'(req_eff);
  assign fin_rise = fin_s2_q & ~fin_s3_q;
  assign tmo_inc  = tmo_cnt_q + TIMEOUT_W'(1);

  // Round-robin search, starting one past the last granted index.
  always_comb begin
    int k;
    arb_found = 1'b0;
    arb_idx   = 3'd0;
    k         = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!arb_found && req_pad[k[2:0]]) begin
        arb_found = 1'b1;
        arb_idx   = k[2:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cfg1_d      = cfg1_q;
    cfg2_d      = cfg2_q;
    grant_d     = '0;
    setup_cnt_d = setup_cnt_q;
    start_cnt_d = start_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    res_data_d  = res_data_q;
    res_tmo_d   = res_tmo_q;
    res_valid_d = res_valid_q;
    start_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d     = SETUP;
          ptr_d       = arb_idx;
          id_d        = arb_idx;
          cfg1_d      = cfg1_arr[arb_idx];
          cfg2_d      = cfg2_arr[arb_idx];
          grant_d     = NUM_REQ'(1) << arb_idx;
          // The grant cycle itself precedes SETUP_CYCLES further hold cycles.
          setup_cnt_d = SW'(SETUP_CYCLES);
        end
      end
      SETUP: begin
        if (setup_cnt_q == '0) begin
          state_d     = START;
          start_cnt_d = TW'(START_CYCLES - 1);
          start_d     = 1'b1;
        end else begin
          setup_cnt_d = setup_cnt_q - SW'(1);
        end
      end
      START: begin
        if (start_cnt_q == '0) begin
          state_d   = WAIT;
          tmo_cnt_d = '0;
        end else begin
          start_d     = 1'b1;
          start_cnt_d = start_cnt_q - TW'(1);
        end
      end
      WAIT: begin
        if (fin_rise) begin
          state_d     = RESP;
          res_data_d  = adc_result_i;
          res_tmo_d   = 1'b0;
          res_valid_d = 1'b1;
        end else if (timeout_i != '0 && tmo_inc == timeout_i) begin
          state_d     = RESP;
          res_data_d  = 16'h0000;
          res_tmo_d   = 1'b1;
          res_valid_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end
      RESP: begin
        if (res_ready_i) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'(NUM_REQ - 1);
      id_q        <= 3'd0;
      cfg1_q      <= 16'h0000;
      cfg2_q      <= 16'h0000;
      grant_q     <= '0;
      setup_cnt_q <= '0;
      start_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      res_data_q  <= 16'h0000;
      res_tmo_q   <= 1'b0;
      res_valid_q <= 1'b0;
      start_q     <= 1'b0;
      fin_s1_q    <= 1'b0;
      fin_s2_q    <= 1'b0;
      fin_s3_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cfg1_q      <= cfg1_d;
      cfg2_q      <= cfg2_d;
      grant_q     <= grant_d;
      setup_cnt_q <= setup_cnt_d;
      start_cnt_q <= start_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      res_data_q  <= res_data_d;
      res_tmo_q   <= res_tmo_d;
      res_valid_q <= res_valid_d;
      start_q     <= start_d;
      fin_s1_q    <= adc_finished_i;
      fin_s2_q    <= fin_s1_q;
      fin_s3_q    <= fin_s2_q;
    end
  end

  assign grant_o        = grant_q;
  assign res_valid_o    = res_valid_q;
  assign res_data_o     = res_data_q;
  assign res_id_o       = id_q;
  assign res_timeout_o  = res_tmo_q;
  assign busy_o         = (state_q != IDLE);
  assign adc_start_o    = start_q;
  assign adc_config_1_o = cfg1_q;
  assign adc_config_2_o = cfg2_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
module tb_adc_conv_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [16*N-1:0] cfg1_bus, cfg2_bus;
  logic [15:0]   timeout;
  logic [N-1:0]  grant_o;
  logic          res_valid_o, res_ready, res_timeout_o, busy_o, adc_start_o;
  logic [15:0]   res_data_o, adc_config_1_o, adc_config_2_o;
  logic [2:0]    res_id_o;
  logic [15:0]   adc_result;
  logic          fin;
`ifdef ADC_SCHED_PERIODIC_EN
  logic [15:0]   trig_period = 16'h0000;
  logic          trig_ovf;
`endif

  always #5 clk = ~clk;

  adc_conv_scheduler #(.NUM_REQ(N), .SETUP_CYCLES(2), .START_CYCLES(4), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ADC_SCHED_PERIODIC_EN
    .trig_period_i(trig_period), .trig_ovf_o(trig_ovf),
`endif
    .req_i(req), .req_config_1_i(cfg1_bus), .req_config_2_i(cfg2_bus),
    .timeout_i(timeout), .grant_o(grant_o), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready), .res_data_o(res_data_o), .res_id_o(res_id_o),
    .res_timeout_o(res_timeout_o), .busy_o(busy_o), .adc_start_o(adc_start_o),
    .adc_config_1_o(adc_config_1_o), .adc_config_2_o(adc_config_2_o),
    .adc_result_i(adc_result), .adc_finished_i(fin)
  );

  typedef struct packed {logic [2:0] id; logic [15:0] data; logic tmo;} res_t;
  res_t exp_res[$];
  int   exp_grant[$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int g_cnt = 0, hs_cnt = 0, g_cyc = 0, s_rise = 0, s_fall = 0, v_rise = 0;

  // ADC model controls: 0 = respond adc_delay cycles after start rise,
  // 1 = never finish, 2 = finished follows fin_lvl directly.
  int          adc_mode = 0;
  int          adc_delay = 20;
  logic        use_xor = 1'b0;
  logic [15:0] fixed_res = 16'h0000;
  logic        fin_lvl = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(int target, int max, string name);
    int n = 0;
    while (g_cnt < target && n < max) begin @(negedge clk); n++; end
    check(name, 32'(g_cnt >= target), 1);
  endtask

  task automatic wait_hs(int target, int max, string name);
    int n = 0;
    while (hs_cnt < target && n < max) begin @(negedge clk); n++; end
    check(name, 32'(hs_cnt >= target), 1);
  endtask

  task automatic wait_sig(int which, int max, string name);
    int n = 0;
    logic s;
    s = 1'b0;
    while (!s && n < max) begin
      @(negedge clk); n++;
      s = (which == 0) ? res_valid_o : adc_start_o;
    end
    check(name, 32'(s), 1);
  endtask

  // ADC model
  initial begin
    int   cnt;
    logic seen;
    cnt = 0; seen = 1'b0; fin = 1'b0; adc_result = 16'h0000;
    forever begin
      @(posedge clk); #1;
      case (adc_mode)
        0: begin
          if (adc_start_o && !seen) begin
            seen = 1'b1; fin = 1'b0; cnt = adc_delay;
          end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
              fin = 1'b1;
              adc_result = use_xor ? (adc_config_1_o ^ 16'hA5A5) : fixed_res;
            end
          end
          if (!adc_start_o) seen = 1'b0;
        end
        1: begin fin = 1'b0; cnt = 0; end
        default: begin fin = fin_lvl; adc_result = fixed_res; cnt = 0; end
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic outstanding, prev_start, prev_valid;
    int   g;
    res_t r;
    outstanding = 1'b0; prev_start = 1'b0; prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 1'b0; prev_start = 1'b0; prev_valid = 1'b0;
      end else begin
        if (grant_o != '0) begin
          if (exp_grant.size() == 0) check("grant_unexpected", 32'(grant_o), 0);
          else begin
            g = exp_grant.pop_front();
            check("grant_onehot", 32'(grant_o), 32'(1) << g);
          end
          check("grant_while_busy", 32'(outstanding), 0);
          outstanding = 1'b1;
          g_cnt++;
          g_cyc = cyc;
        end
        if (adc_start_o && !prev_start) s_rise = cyc;
        if (!adc_start_o && prev_start) s_fall = cyc;
        prev_start = adc_start_o;
        if (res_valid_o && !prev_valid) v_rise = cyc;
        prev_valid = res_valid_o;
        if (res_valid_o && res_ready) begin
          if (exp_res.size() == 0) check("result_unexpected", 32'(res_valid_o), 0);
          else begin
            r = exp_res.pop_front();
            check("res_id", 32'(res_id_o), 32'(r.id));
            check("res_data", 32'(res_data_o), 32'(r.data));
            check("res_timeout", 32'(res_timeout_o), 32'(r.tmo));
          end
          outstanding = 1'b0;
          hs_cnt++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; res_ready = 1'b1; timeout = 16'd0;
    cfg1_bus = {16'h3333, 16'h2222, 16'h1111, 16'h0C03};
    cfg2_bus = {16'h3F3F, 16'h2F2F, 16'h1F1F, 16'h00F0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant_o), 0);
    check("rst_valid", 32'(res_valid_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_start", 32'(adc_start_o), 0);
    check("rst_cfg1", 32'(adc_config_1_o), 0);
    check("rst_cfg2", 32'(adc_config_2_o), 0);
    check("rst_data", 32'(res_data_o), 0);
    check("rst_id", 32'(res_id_o), 0);
    check("rst_timeout", 32'(res_timeout_o), 0);
    step(1); rst_n = 1'b1;

    // Single conversion, requester 0, req dropped after grant
    adc_mode = 0; use_xor = 1'b0; fixed_res = 16'h0ABC;
    exp_grant.push_back(0);
    exp_res.push_back({3'd0, 16'h0ABC, 1'b0});
    step(1); req = 4'b0001;
    wait_grants(1, 20, "t1_grant_wait");
    check("t1_cfg1", 32'(adc_config_1_o), 32'h0C03);
    check("t1_cfg2", 32'(adc_config_2_o), 32'h00F0);
    step(1); req = 4'b0000;
    wait_hs(1, 200, "t1_hs_wait");
    check("t1_start_latency", 32'(s_rise - g_cyc), 3);
    check("t1_start_width", 32'(s_fall - s_rise), 4);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy_o), 0);
    check("t1_idle_valid", 32'(res_valid_o), 0);
    check("t1_cfg_retained", 32'(adc_config_1_o), 32'h0C03);

    // Reset pulse, then round-robin with all requests held
    step(1); rst_n = 1'b0;
    @(negedge clk);
    check("t2_rst_cfg1", 32'(adc_config_1_o), 0);
    step(1); rst_n = 1'b1;
    use_xor = 1'b1;
    foreach (exp_grant[i]) check("t2_grant_q_empty", 1, 0);
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    exp_grant.push_back(3); exp_grant.push_back(0);
    exp_res.push_back({3'd0, 16'hA9A6, 1'b0});
    exp_res.push_back({3'd1, 16'hB4B4, 1'b0});
    exp_res.push_back({3'd2, 16'h8787, 1'b0});
    exp_res.push_back({3'd3, 16'h9696, 1'b0});
    exp_res.push_back({3'd0, 16'hA9A6, 1'b0});
    begin
      int gb, hb;
      gb = g_cnt; hb = hs_cnt;
      req = 4'b1111;
      wait_grants(gb + 5, 400, "t2_grant_wait");
      step(1); req = 4'b0000;
      wait_hs(hb + 5, 300, "t2_hs_wait");
    end

    // Backpressure: ready low for 10 cycles in RESP, another request waiting
    step(1);
    res_ready = 1'b0;
    exp_grant.push_back(1); exp_grant.push_back(2);
    exp_res.push_back({3'd1, 16'hB4B4, 1'b0});
    exp_res.push_back({3'd2, 16'h8787, 1'b0});
    begin
      int gb, hb;
      gb = g_cnt; hb = hs_cnt;
      req = 4'b0110;
      wait_grants(gb + 1, 20, "t3_grant_wait");
      wait_sig(0, 200, "t3_valid_wait");
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("t3_bp_valid", 32'(res_valid_o), 1);
        check("t3_bp_data", 32'(res_data_o), 32'hB4B4);
        check("t3_bp_id", 32'(res_id_o), 1);
        check("t3_bp_nogrant", 32'(grant_o), 0);
      end
      @(posedge clk); #1; res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t3_post_hs_busy", 32'(busy_o), 0);
      check("t3_post_hs_valid", 32'(res_valid_o), 0);
      wait_grants(gb + 2, 20, "t3_grant2_wait");
      step(1); req = 4'b0000;
      wait_hs(hb + 2, 200, "t3_hs_wait");
    end

    // Timeout of 50 cycles with a silent ADC
    step(1);
    adc_mode = 1; timeout = 16'd50;
    exp_grant.push_back(2);
    exp_res.push_back({3'd2, 16'h0000, 1'b1});
    begin
      int gb, hb;
      gb = g_cnt; hb = hs_cnt;
      req = 4'b0100;
      wait_grants(gb + 1, 20, "t4_grant_wait");
      step(1); req = 4'b0000;
      wait_hs(hb + 1, 200, "t4_hs_wait");
      check("t4_timeout_latency", 32'(v_rise - s_fall), 50);
    end

    // Timeout disabled: stays in WAIT until a finished edge arrives
    step(1);
    timeout = 16'd0;
    exp_grant.push_back(3);
    exp_res.push_back({3'd3, 16'h1234, 1'b0});
    begin
      int gb, hb;
      gb = g_cnt; hb = hs_cnt;
      req = 4'b1000;
      wait_grants(gb + 1, 20, "t5_grant_wait");
      step(1); req = 4'b0000;
      step(200);
      @(negedge clk);
      check("t5_wait_busy", 32'(busy_o), 1);
      check("t5_wait_valid", 32'(res_valid_o), 0);
      check("t5_wait_start", 32'(adc_start_o), 0);
      step(1);
      fin_lvl = 1'b0; fixed_res = 16'h1234; adc_mode = 2;
      step(2); fin_lvl = 1'b1;
      wait_hs(hb + 1, 20, "t5_hs_wait");
    end

    // Stale finished already high; only a fresh edge is captured
    step(1);
    fixed_res = 16'hDEAD;
    exp_grant.push_back(0);
    exp_res.push_back({3'd0, 16'h5555, 1'b0});
    begin
      int gb, hb;
      gb = g_cnt; hb = hs_cnt;
      req = 4'b0001;
      wait_grants(gb + 1, 20, "t6_grant_wait");
      step(1); req = 4'b0000;
      step(30);
      @(negedge clk);
      check("t6_stale_valid", 32'(res_valid_o), 0);
      check("t6_stale_busy", 32'(busy_o), 1);
      step(1); fin_lvl = 1'b0;
      step(3); fixed_res = 16'h5555; fin_lvl = 1'b1;
      wait_hs(hb + 1, 20, "t6_hs_wait");
    end

    // Reset asserted during START
    step(1);
    adc_mode = 0; use_xor = 1'b1;
    exp_grant.push_back(1);
    begin
      int gb, hb;
      gb = g_cnt;
      req = 4'b0010;
      wait_grants(gb + 1, 20, "t7_grant_wait");
      wait_sig(1, 20, "t7_start_wait");
      #2 rst_n = 1'b0;
      #1;
      check("t7_rst_start", 32'(adc_start_o), 0);
      check("t7_rst_busy", 32'(busy_o), 0);
      check("t7_rst_valid", 32'(res_valid_o), 0);
      req = 4'b0111;
      step(2);
      exp_grant.push_back(0);
      exp_res.push_back({3'd0, 16'hA9A6, 1'b0});
      gb = g_cnt; hb = hs_cnt;
      rst_n = 1'b1;
      @(negedge clk);
      check("t7_release_busy", 32'(busy_o), 0);
      wait_grants(gb + 1, 20, "t7_grant2_wait");
      step(1); req = 4'b0000;
      wait_hs(hb + 1, 200, "t7_hs_wait");
    end

    step(5);
    check("end_grant_queue", 32'(exp_grant.size()), 0);
    check("end_result_queue", 32'(exp_res.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
